// File: rtl/coeff_pkg.sv
// coeff_pkg: shared constants, default coefficient bank and FSM states for the coefficient loader
package coeff_pkg;
  localparam int N_WORDS = 21;
  localparam int WORD_W = 16;
  localparam int FRAME_W = N_WORDS * WORD_W;
  localparam logic [WORD_W-1:0] COEFF_ONE = 16'h4000;
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;
  localparam int STAGE_STRIDE = 5;
  localparam int GAIN_IDX = 20;
  typedef enum logic [1:0] {IDLE, SAMPLE, VERIFY, PENDING} state_t;
  // word 0 sits in the top bits because it is the first word shifted in
  function automatic logic [WORD_W-1:0] coeff_word(input logic [FRAME_W-1:0] frame, input int k);
    return frame[FRAME_W-1-k*WORD_W -: WORD_W];
  endfunction
  // unity passthrough: every b0 and the master gain at 1.0, everything else zero
  function automatic logic [FRAME_W-1:0] default_bank();
    logic [FRAME_W-1:0] b;
    b = '0;
    for (int k = 0; k < N_WORDS; k++)
      if (k % STAGE_STRIDE == B0 || k == GAIN_IDX) b[FRAME_W-1-k*WORD_W -: WORD_W] = COEFF_ONE;
    return b;
  endfunction
  localparam logic [FRAME_W-1:0] DEFAULT_BANK = default_bank();
endpackage

// File: rtl/sync_pulse.sv
// sync_pulse: multi-flop synchroniser followed by a rising-edge detector
module sync_pulse #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic pulse
);
  logic [STAGES-1:0] sync;
  logic prev;
  // shift the async level through the chain and remember the last synchronised value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end
  assign pulse = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/spi_coeff_loader.sv
// spi_coeff_loader: moves a verified SPI coefficient frame into the live bank on a sample boundary
module spi_coeff_loader
  import coeff_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FRAME_W-1:0] spi_data,
  input  logic               spi_valid,
  input  logic               sample_tick,
  output logic [FRAME_W-1:0] coeff_out,
  output logic               coeff_update,
  output logic               pending,
  output logic [7:0]         frame_count,
  output logic               drop_err
);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_t state, state_nx;
  logic [RW-1:0] retry, retry_nx;
  logic [FRAME_W-1:0] shadow;
  logic valid_edge, load, commit, drop;
  sync_pulse #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (spi_valid),
    .pulse (valid_edge)
  );
  // the bus is never synchronised; two samples that agree prove it has settled
  always_comb begin
    state_nx = state;
    retry_nx = retry;
    load = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: state_nx = valid_edge ? SAMPLE : IDLE;
      SAMPLE: begin
        load = 1'b1;
        state_nx = VERIFY;
      end
      VERIFY:
        if (spi_data == shadow) begin
          state_nx = PENDING;
          retry_nx = '0;
        end else if (retry < RW'(MAX_RETRY)) begin
          state_nx = SAMPLE;
          retry_nx = retry + 1'b1;
        end else begin
          state_nx = IDLE;
          retry_nx = '0;
          drop = 1'b1;
        end
      PENDING: begin
        commit = sample_tick;
        state_nx = valid_edge ? SAMPLE : sample_tick ? IDLE : PENDING;
      end
      default: state_nx = IDLE;
    endcase
  end
  // FSM state and retry counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      retry <= '0;
    end else begin
      state <= state_nx;
      retry <= retry_nx;
    end
  end
  // shadow captures the bus for comparison; a dropped frame leaves nothing behind
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow <= '0;
    else if (load) shadow <= spi_data;
    else if (drop) shadow <= '0;
  end
  // live bank changes as a whole only on a commit, so the filter never sees a half-updated set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coeff_out <= DEFAULT_BANK;
      frame_count <= '0;
    end else if (commit) begin
      coeff_out <= shadow;
      frame_count <= frame_count + 8'd1;
    end
  end
  assign coeff_update = commit;
  assign drop_err = drop;
  assign pending = state == PENDING;
endmodule

// File: tb/tb_spi_coeff_loader.sv
// tb_spi_coeff_loader: randomized self-checking bench for the coefficient loader
module tb_spi_coeff_loader;
  localparam int NW = 21;
  localparam int FW = NW * 16;
  logic clk = 1'b0;
  logic reset;
  logic [FW-1:0] spi_data;
  logic spi_valid;
  logic sample_tick;
  logic [FW-1:0] coeff_out;
  logic coeff_update;
  logic pending;
  logic [7:0] frame_count;
  logic drop_err;
  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int drop_cnt = 0;
  logic [FW-1:0] exp_bank;
  int exp_count;

  spi_coeff_loader dut (
    .clk          (clk),
    .reset        (reset),
    .spi_data     (spi_data),
    .spi_valid    (spi_valid),
    .sample_tick  (sample_tick),
    .coeff_out    (coeff_out),
    .coeff_update (coeff_update),
    .pending      (pending),
    .frame_count  (frame_count),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coeff_update === 1'b1) upd_cnt++;
    if (drop_err === 1'b1) drop_cnt++;
  end

  function automatic logic [FW-1:0] ref_default();
    logic [FW-1:0] b;
    b = '0;
    for (int k = 0; k < NW; k += 5) b[FW-1-k*16 -: 16] = 16'h4000;
    return b;
  endfunction

  function automatic logic [15:0] word_of(input logic [FW-1:0] f, input int k);
    return f[FW-1-k*16 -: 16];
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int k = 0; k < NW; k++) f[FW-1-k*16 -: 16] = 16'($urandom);
    return f;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pending(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 24 && !seen; i++) begin
      @(negedge clk);
      seen = pending === 1'b1;
    end
    @(posedge clk);
    #1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s pending: got 0 within 24 clk, want 1", name);
    end
  endtask

  task automatic load_frame(input logic [FW-1:0] f, input string name);
    spi_data = f;
    spi_valid = 1'b1;
    wait_pending(name);
    spi_valid = 1'b0;
    wait_clk(4);
  endtask

  task automatic do_tick(input logic [FW-1:0] f, input bit commit, input string name);
    sample_tick = 1'b1;
    @(negedge clk);
    checks++;
    if (coeff_update !== commit) begin
      errors++;
      $display("FAIL %s coeff_update: got %b want %b", name, coeff_update, commit);
    end
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    if (commit) begin
      exp_bank = f;
      exp_count = (exp_count + 1) % 256;
    end
    checks++;
    if (coeff_out !== exp_bank) begin
      errors++;
      $display("FAIL %s coeff_out: got %h want %h", name, coeff_out, exp_bank);
    end
    checks++;
    if (frame_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL %s frame_count: got %0d want %0d", name, frame_count, exp_count);
    end
  endtask

  task automatic test_reset();
    int u0, d0;
    reset = 1'b1;
    spi_data = '0;
    spi_valid = 1'b0;
    sample_tick = 1'b0;
    exp_bank = ref_default();
    exp_count = 0;
    wait_clk(3);
    reset = 1'b0;
    u0 = upd_cnt;
    d0 = drop_cnt;
    wait_clk(100);
    checks++;
    if (coeff_out !== exp_bank) begin
      errors++;
      $display("FAIL reset coeff_out: got %h want %h", coeff_out, exp_bank);
    end
    checks++;
    if (frame_count !== 8'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL reset count/pending: got %0d/%b want 0/0", frame_count, pending);
    end
    checks++;
    if (upd_cnt != u0 || drop_cnt != d0) begin
      errors++;
      $display("FAIL reset pulses: got %0d updates %0d drops want 0 0", upd_cnt - u0, drop_cnt - d0);
    end
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    for (int k = 0; k < NW; k++) f[FW-1-k*16 -: 16] = 16'h0100 + 16'(k);
    spi_data = f;
    spi_valid = 1'b1;
    wait_pending("basic");
    wait_clk(10);
    do_tick(f, 1'b1, "basic");
    checks++;
    if (word_of(coeff_out, 7) !== 16'h0107) begin
      errors++;
      $display("FAIL basic word7: got %h want 0107", word_of(coeff_out, 7));
    end
    spi_valid = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_idle_ticks();
    logic [FW-1:0] f;
    int u0;
    do_tick(f, 1'b0, "idle_tick1");
    wait_clk(2);
    do_tick(f, 1'b0, "idle_tick2");
    f = rand_frame();
    u0 = upd_cnt;
    load_frame(f, "idle_load");
    checks++;
    if (upd_cnt != u0) begin
      errors++;
      $display("FAIL idle early_commit: got %0d updates want 0", upd_cnt - u0);
    end
    do_tick(f, 1'b1, "idle_commit");
    checks++;
    if (upd_cnt - u0 != 1) begin
      errors++;
      $display("FAIL idle update_count: got %0d want 1", upd_cnt - u0);
    end
  endtask

  task automatic test_retry();
    logic [FW-1:0] g;
    int u0, d0;
    u0 = upd_cnt;
    d0 = drop_cnt;
    spi_data = rand_frame();
    spi_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wait_clk(1);
      spi_data = ~spi_data;
    end
    wait_clk(2);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL retry_drop drop_err: got %0d pulses want 1", drop_cnt - d0);
    end
    checks++;
    if (upd_cnt != u0 || pending !== 1'b0 || coeff_out !== exp_bank) begin
      errors++;
      $display("FAIL retry_drop state: got %0d updates pending %b want 0 updates pending 0", upd_cnt - u0, pending);
    end
    do_tick(g, 1'b0, "retry_drop_tick");
    spi_valid = 1'b0;
    wait_clk(4);
    d0 = drop_cnt;
    spi_data = rand_frame();
    spi_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_clk(1);
      spi_data = rand_frame();
    end
    g = spi_data;
    wait_pending("retry_ok");
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL retry_ok drop_err: got %0d pulses want 0", drop_cnt - d0);
    end
    do_tick(g, 1'b1, "retry_ok");
    spi_valid = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_supersede();
    logic [FW-1:0] a, b;
    int u0;
    a = rand_frame();
    b = rand_frame();
    load_frame(a, "supersede_a");
    u0 = upd_cnt;
    spi_data = b;
    spi_valid = 1'b1;
    wait_clk(6);
    wait_pending("supersede_b");
    checks++;
    if (upd_cnt != u0 || coeff_out !== exp_bank) begin
      errors++;
      $display("FAIL supersede early_commit: got %0d updates want 0", upd_cnt - u0);
    end
    do_tick(b, 1'b1, "supersede_commit");
    spi_valid = 1'b0;
    wait_clk(4);
    do_tick(a, 1'b0, "supersede_no_a");
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] a, b;
    a = rand_frame();
    b = rand_frame();
    load_frame(a, "b2b_a");
    spi_data = b;
    spi_valid = 1'b1;
    wait_clk(2);
    do_tick(a, 1'b1, "b2b_commit_a");
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b reload: got pending %b want 0", pending);
    end
    wait_pending("b2b_b");
    do_tick(b, 1'b1, "b2b_commit_b");
    spi_valid = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_reset_pending();
    logic [FW-1:0] f;
    f = rand_frame();
    load_frame(f, "rst_load");
    reset = 1'b1;
    #1;
    exp_bank = ref_default();
    exp_count = 0;
    checks++;
    if (coeff_out !== exp_bank || pending !== 1'b0 || frame_count !== 8'd0 || coeff_update !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got count %0d pending %b update %b bank %h want 0 0 0 default", frame_count, pending, coeff_update, coeff_out);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_clk(2);
    do_tick(f, 1'b0, "rst_tick");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 256; i++) begin
      logic [FW-1:0] f;
      f = rand_frame();
      load_frame(f, "wrap_load");
      do_tick(f, 1'b1, "wrap");
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap frame_count: got %0d want 0", frame_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_ticks();
    test_retry();
    test_supersede();
    test_back_to_back();
    test_reset_pending();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
